// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle adder/subtractor. Operands are accepted on a valid/ready
//   handshake, then added CHUNK bits per clock with the carry rippled through
//   a register between chunks. Once the last chunk is done, the result and
//   its flags are presented on a second valid/ready handshake.
//
//   Subtraction is done as a + ~b + ~cin. The inversion happens when the
//   operands are captured, so the datapath only ever adds.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 1)
//   CHUNK      bits processed per clock; must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands a, b, cin and sub are valid
//   in_ready   block can take operands (IDLE only, low while rst is high)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in for add, borrow-in for subtract
//   sub        0: a + b + cin, 1: a - b - cin
//   out_valid  result outputs are valid
//   out_ready  sink accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 means no borrow)
//   overflow   signed two's-complement overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   // Stop elaboration on a parameter set that cannot be split into chunks.
   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("serial_addsub: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic             carry_q,     carry_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic             cout_q,      cout_d;
   logic             overflow_q,  overflow_d;
   logic             zero_q,      zero_d;
   logic             out_valid_q, out_valid_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   chunk_res;
   logic             last_chunk;

   // Operands are taken only in IDLE. The term on rst keeps the source from
   // seeing a handshake while the block is being held in reset.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

   // Pick the operand chunk that the counter points at. The loop index is a
   // constant, so every part-select is static and becomes a plain mux.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_q == CW'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
      chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      last_chunk = (cnt_q == CW'(NCHUNK - 1));
   end

   // Next-state logic for the FSM and datapath. In RUN, only the chunk under
   // the counter is written into sum, and the other bits keep their value.
   // The flags are formed on the last chunk, using the sum value that is
   // about to be registered.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = cin ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
               end
            end
            carry_d = chunk_res[CHUNK];
            if (last_chunk) begin
               cnt_d       = '0;
               cout_d      = chunk_res[CHUNK];
               overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (sum_d[WIDTH-1] != a_q[WIDTH-1]);
               zero_d      = (sum_d == '0);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // All state registers are in one block. Reset drops any operation in
   // flight and clears the result, so a partial sum is never visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Bench for serial_addsub. Four instances cover different WIDTH/CHUNK
//   pairs (8/1, 8/4, 16/2, 32/8). They share operand, reset and out_ready
//   drives, and each has its own in_valid. A selector routes the outputs of
//   one instance to a common set of observation signals.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] aIn;
   logic [31:0] bIn;
   logic        cinIn;
   logic        subIn;
   logic        outReady;
   logic [3:0]  inValid;
   logic [3:0]  inReady;
   logic [3:0]  outValid;
   logic [3:0]  coutO;
   logic [3:0]  ovfO;
   logic [3:0]  zeroO;
   logic [7:0]  sum0;
   logic [7:0]  sum1;
   logic [15:0] sum2;
   logic [31:0] sum3;

   logic [1:0]  sel;
   logic [31:0] curSum;
   logic        curCout;
   logic        curOvf;
   logic        curZero;
   logic        curOutValid;
   logic        curInReady;

   int checks = 0;
   int fails  = 0;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .CHUNK(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
      .a(aIn[7:0]), .b(bIn[7:0]), .cin(cinIn), .sub(subIn),
      .out_valid(outValid[0]), .out_ready(outReady), .sum(sum0),
      .cout(coutO[0]), .overflow(ovfO[0]), .zero(zeroO[0]));

   serial_addsub #(.WIDTH(8), .CHUNK(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
      .a(aIn[7:0]), .b(bIn[7:0]), .cin(cinIn), .sub(subIn),
      .out_valid(outValid[1]), .out_ready(outReady), .sum(sum1),
      .cout(coutO[1]), .overflow(ovfO[1]), .zero(zeroO[1]));

   serial_addsub #(.WIDTH(16), .CHUNK(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
      .a(aIn[15:0]), .b(bIn[15:0]), .cin(cinIn), .sub(subIn),
      .out_valid(outValid[2]), .out_ready(outReady), .sum(sum2),
      .cout(coutO[2]), .overflow(ovfO[2]), .zero(zeroO[2]));

   serial_addsub #(.WIDTH(32), .CHUNK(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(inReady[3]),
      .a(aIn), .b(bIn), .cin(cinIn), .sub(subIn),
      .out_valid(outValid[3]), .out_ready(outReady), .sum(sum3),
      .cout(coutO[3]), .overflow(ovfO[3]), .zero(zeroO[3]));

   // Route the selected instance's outputs onto the common observation signals.
   always_comb begin
      curSum = '0;
      case (sel)
         2'd0:    curSum = {24'd0, sum0};
         2'd1:    curSum = {24'd0, sum1};
         2'd2:    curSum = {16'd0, sum2};
         default: curSum = sum3;
      endcase
      curCout     = coutO[sel];
      curOvf      = ovfO[sel];
      curZero     = zeroO[sel];
      curOutValid = outValid[sel];
      curInReady  = inReady[sel];
   end

   function automatic int widthOf(input int idx);
      case (idx)
         0:       return 8;
         1:       return 8;
         2:       return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int nChunkOf(input int idx);
      case (idx)
         0:       return 8;
         1:       return 2;
         2:       return 8;
         default: return 4;
      endcase
   endfunction

   // Reference model based on exact integer arithmetic.
   // The carry/borrow comes from the wide result. Overflow means the exact
   // signed result falls outside the signed range of the width.
   function automatic void goldenModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic cin, input logic sub,
                                       output logic [31:0] s, output logic co,
                                       output logic ov, output logic z);
      longint mask;
      longint ua;
      longint ub;
      longint sa;
      longint sb;
      longint r;
      longint ex;
      longint half;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
      if (!sub) begin
         r  = ua + ub + longint'(cin);
         co = ((r >> w) & 1) != 0;
         ex = sa + sb + longint'(cin);
      end else begin
         r  = ua - ub - longint'(cin);
         co = (ua >= ub + longint'(cin));
         ex = sa - sb - longint'(cin);
      end
      s  = 32'(r & mask);
      ov = (ex > half - 1) || (ex < -half);
      z  = ((r & mask) == 0);
   endfunction

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Run one operation through instance idx. The bench checks the input
   // handshake, the exact latency, and the result and flags. It holds
   // out_ready low for 'stall' cycles while pushing a new in_valid that the
   // block must ignore, then releases out_ready and checks the return to IDLE.
   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub, input int stall,
                                input logic [31:0] eSum, input logic eCout,
                                input logic eOvf, input logic eZero, input string tag);
      int lat;
      sel = 2'(idx);
      @(negedge clk);
      aIn          = a;
      bIn          = b;
      cinIn        = cin;
      subIn        = sub;
      outReady     = 1'b0;
      inValid[idx] = 1'b1;
      #1;
      checkOutput({tag, ".inReadyIdle"}, 64'(curInReady), 64'd1);
      @(posedge clk);
      #1;
      inValid[idx] = 1'b0;
      aIn          = ~a;
      bIn          = ~b;
      cinIn        = ~cin;
      subIn        = ~sub;
      checkOutput({tag, ".inReadyBusy"}, 64'(curInReady), 64'd0);
      lat = 0;
      while (!curOutValid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, ".latency"}, 64'(lat), 64'(nChunkOf(idx)));
      checkOutput({tag, ".sum"}, 64'(curSum), 64'(eSum));
      checkOutput({tag, ".cout"}, 64'(curCout), 64'(eCout));
      checkOutput({tag, ".overflow"}, 64'(curOvf), 64'(eOvf));
      checkOutput({tag, ".zero"}, 64'(curZero), 64'(eZero));
      for (int i = 0; i < stall; i++) begin
         aIn          = 32'h0000_0001;
         bIn          = 32'h0000_0001;
         inValid[idx] = 1'b1;
         @(posedge clk);
         #1;
         checkOutput({tag, ".stallValid"}, 64'(curOutValid), 64'd1);
         checkOutput({tag, ".stallSum"}, 64'(curSum), 64'(eSum));
         checkOutput({tag, ".stallFlags"}, {61'd0, curCout, curOvf, curZero},
                     {61'd0, eCout, eOvf, eZero});
         checkOutput({tag, ".stallInReady"}, 64'(curInReady), 64'd0);
      end
      inValid[idx] = 1'b0;
      outReady     = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput({tag, ".validDrop"}, 64'(curOutValid), 64'd0);
      checkOutput({tag, ".backToIdle"}, 64'(curInReady), 64'd1);
   endtask

   // Run one operation with random operands on instance idx and compare it
   // against the reference model.
   task automatic randomOp(input int idx, input string tag);
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      logic [31:0] eS;
      logic        eC;
      logic        eV;
      logic        eZ;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      goldenModel(widthOf(idx), ra, rb, rc, rs, eS, eC, eV, eZ);
      applyStimulus(idx, ra, rb, rc, rs, int'($urandom_range(0, 3)), eS, eC, eV, eZ, tag);
   endtask

   // Directed scenarios first, then a randomized sweep, then the summary line.
   initial begin
      int sawValid;
      rst      = 1'b1;
      aIn      = '0;
      bIn      = '0;
      cinIn    = 1'b0;
      subIn    = 1'b0;
      outReady = 1'b0;
      inValid  = '0;
      sel      = 2'd0;

      // Check the reset state while reset is held, then the handshake after release.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.inReady", 64'(inReady), 64'h0);
      checkOutput("rst.outValid", 64'(outValid), 64'h0);
      checkOutput("rst.flags", {52'd0, coutO, ovfO, zeroO}, 64'h0);
      checkOutput("rst.sum3", 64'(sum3), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst.inReadyRelease", 64'(inReady), 64'hF);

      // 8-bit, 1 bit per cycle: signed overflow, then carry-out with a zero result.
      applyStimulus(0, 32'h7F, 32'h01, 1'b0, 1'b0, 3, 32'h80, 1'b0, 1'b1, 1'b0, "t1.add7F");
      applyStimulus(0, 32'hFF, 32'h01, 1'b0, 1'b0, 0, 32'h00, 1'b1, 1'b0, 1'b1, "t2.addFF");
      applyStimulus(0, 32'h00, 32'h00, 1'b1, 1'b1, 0, 32'hFF, 1'b0, 1'b0, 1'b0, "t2.subBorrow");

      // 8-bit, 4 bits per cycle: subtraction with borrow and with overflow.
      applyStimulus(1, 32'h05, 32'h07, 1'b0, 1'b1, 0, 32'hFE, 1'b0, 1'b0, 1'b0, "t3.sub05");
      applyStimulus(1, 32'h80, 32'h01, 1'b0, 1'b1, 1, 32'h7F, 1'b1, 1'b1, 1'b0, "t3.sub80");

      // 16-bit, 2 bits per cycle: a long output stall, then the next operation issued at once.
      applyStimulus(2, 32'h1234, 32'h4321, 1'b0, 1'b0, 5, 32'h5555, 1'b0, 1'b0, 1'b0, "t4.stall");
      applyStimulus(2, 32'h8000, 32'h8000, 1'b0, 1'b0, 0, 32'h0000, 1'b1, 1'b1, 1'b1, "t4.next");

      // Assert reset partway through RUN: the operation must be abandoned cleanly.
      sel = 2'd0;
      @(negedge clk);
      aIn        = 32'h55;
      bIn        = 32'h0F;
      cinIn      = 1'b0;
      subIn      = 1'b0;
      inValid[0] = 1'b1;
      @(posedge clk);
      #1;
      inValid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("t5.rstValid", 64'(curOutValid), 64'd0);
      checkOutput("t5.rstSum", 64'(curSum), 64'd0);
      checkOutput("t5.rstFlags", {61'd0, curCout, curOvf, curZero}, 64'd0);
      checkOutput("t5.rstInReady", 64'(curInReady), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("t5.inReadyAfter", 64'(curInReady), 64'd1);
      sawValid = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (curOutValid) sawValid++;
      end
      checkOutput("t5.noValid", 64'(sawValid), 64'd0);
      applyStimulus(0, 32'h10, 32'h20, 1'b1, 1'b0, 0, 32'h31, 1'b0, 1'b0, 1'b0, "t5.after");

      // Random sweep over several chunk sizes, with random output stalls.
      for (int k = 0; k < 12; k++) begin
         randomOp(0, "t6.w8c1");
         randomOp(1, "t6.w8c4");
         randomOp(2, "t6.w16c2");
         randomOp(3, "t6.w32c8");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
